// File: rtl/arith_pkg.sv
// Shared encodings for the sequential arithmetic unit: op codes, FSM states
// and the counter-width helper.
package arith_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_SHL = 3'd2,
        OP_SHR = 3'd3,
        OP_MUL = 3'd4,
        OP_DIV = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/arith_addsub.sv
// W-bit ripple adder/subtractor built from per-bit full-adder cells.
// cb is the carry out when adding and the borrow out when subtracting.
module arith_addsub
    import arith_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         cb
);

    logic [W:0]   c;
    logic [W-1:0] bx;

    // Subtraction is a + ~b + 1; the carry-in supplies the +1.
    assign bx   = b ^ {W{sub}};
    assign c[0] = sub;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum[i]   = a[i] ^ bx[i] ^ c[i];
        assign c[i + 1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end

    assign cb = c[W] ^ sub;

endmodule

// File: rtl/seq_arith_unit.sv
// Clocked arithmetic unit: one-cycle add/sub/shift plus W-cycle shift-add
// multiply and restoring divide, under a start/done handshake.
module seq_arith_unit
    import arith_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2:0]     op,
    input  logic [W-1:0]   op_a,
    input  logic [W-1:0]   op_b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] result,
    output logic           flag
);

    localparam int CW = (clog2(W) < 1) ? 1 : clog2(W);

    state_e          state, state_nx;
    op_e             op_in;
    logic [CW-1:0]   cnt;
    logic            is_div;
    logic [W-1:0]    hi, lo, dsr;
    logic [W-1:0]    add_a, add_b, add_s;
    logic            add_sub, add_cb;
    logic [W-1:0]    rem_sh, hi_nx, lo_nx;
    logic            ge, op_multi;
    logic [2*W-1:0]  z, quick_res;
    logic            quick_flag;

    assign op_in    = op_e'(op);
    assign op_multi = (op_in == OP_MUL) || ((op_in == OP_DIV) && (op_b != '0));
    assign z        = {op_b, op_a};
    assign rem_sh   = {hi[W-2:0], lo[W-1]};

    arith_addsub #(.W(W)) u_addsub (
        .a   (add_a),
        .b   (add_b),
        .sub (add_sub),
        .sum (add_s),
        .cb  (add_cb)
    );

    // The single adder serves the operands in IDLE and the iterative step in RUN.
    always_comb begin
        add_a   = op_a;
        add_b   = op_b;
        add_sub = (op_in == OP_SUB);
        if (state == ST_RUN) begin
            if (is_div) begin
                add_a   = rem_sh;
                add_b   = dsr;
                add_sub = 1'b1;
            end else begin
                add_a   = hi;
                add_b   = lo[0] ? dsr : '0;
                add_sub = 1'b0;
            end
        end
    end

    // A set remainder MSB means the shifted remainder exceeds any W-bit divisor.
    always_comb begin
        ge = hi[W-1] | ~add_cb;
        if (is_div) begin
            hi_nx = ge ? add_s : rem_sh;
            lo_nx = {lo[W-2:0], ge};
        end else begin
            hi_nx = {add_cb, add_s[W-1:1]};
            lo_nx = {add_s[0], lo[W-1:1]};
        end
    end

    always_comb begin
        quick_res  = '0;
        quick_flag = 1'b0;
        case (op_in)
            OP_ADD: begin
                quick_res  = {{(W-1){1'b0}}, add_cb, add_s};
                quick_flag = add_cb;
            end
            OP_SUB: begin
                quick_res  = {{W{1'b0}}, add_s};
                quick_flag = add_cb;
            end
            OP_SHL: begin
                quick_res  = {z[2*W-2:0], 1'b0};
                quick_flag = z[2*W-1];
            end
            OP_SHR: begin
                quick_res  = {1'b0, z[2*W-1:1]};
                quick_flag = z[0];
            end
            OP_DIV: begin
                quick_res  = {op_a, {W{1'b1}}};
                quick_flag = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = op_multi ? ST_RUN : ST_FIN;
            ST_RUN:  if (cnt == '0) state_nx = ST_FIN;
            ST_FIN:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            is_div <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            dsr    <= '0;
            result <= '0;
            flag   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (op_multi) begin
                            is_div <= (op_in == OP_DIV);
                            hi     <= '0;
                            lo     <= (op_in == OP_DIV) ? op_a : op_b;
                            dsr    <= (op_in == OP_DIV) ? op_b : op_a;
                            cnt    <= CW'(W - 1);
                        end else begin
                            result <= quick_res;
                            flag   <= quick_flag;
                        end
                    end
                end
                ST_RUN: begin
                    hi <= hi_nx;
                    lo <= lo_nx;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        result <= {hi_nx, lo_nx};
                        flag   <= is_div ? 1'b0 : (hi_nx != '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_FIN);

endmodule
